// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with a load/store request port and a registered response.
// Latency: 1 cycle for an access within one row, 2 cycles for a row-crossing access.
// Backpressure: req_ready drops for one cycle while a split access runs; the macro
// DATA_MEM_PIPE_MISALIGN_EN enables split accesses, otherwise misaligned accesses error.
module data_mem_pipe #(
   parameter int REG_WIDTH  = 64,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_width,
   input  logic                 req_sign,
   input  logic [REG_WIDTH-1:0] req_addr,
   input  logic [REG_WIDTH-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [REG_WIDTH-1:0] resp_rdata,
   output logic                 resp_err
);
   localparam int NB    = REG_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef DATA_MEM_PIPE_MISALIGN_EN
   localparam int OFFW = $clog2(NB);
   typedef enum logic [0:0] {IDLE, SPLIT} state_t;
`else
   typedef enum logic [0:0] {IDLE} state_t;
`endif

   // Memory contents survive reset, so the array has no reset branch.
   logic [7:0] mem [0:DEPTH-1];

   state_t                state, state_nxt;
   logic                  up_q;
   logic                  accept, in_split;
   logic [ADDR_WIDTH-1:0] a_addr;
   int                    a_size;
   logic                  a_illegal, a_cross;

   logic [ADDR_WIDTH-1:0] x_addr;
   logic [1:0]            x_width;
   logic                  x_sign, x_we, x_go;
   logic [REG_WIDTH-1:0]  x_wdata;
   int                    x_size;
   logic [REG_WIDTH-1:0]  rd_raw, rd_ext;
   logic                  rd_msb;

   // Address bits above the byte capacity are ignored: the space wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[REG_WIDTH-1:ADDR_WIDTH];

   assign req_ready = up_q && (state == IDLE);
   assign accept    = req_valid && req_ready;

`ifdef DATA_MEM_PIPE_MISALIGN_EN
   assign in_split = (state == SPLIT);
   logic [ADDR_WIDTH-1:0] l_addr;
   logic [1:0]            l_width;
   logic                  l_sign, l_we;
   logic [REG_WIDTH-1:0]  l_wdata;

   // Hold a row-crossing request until the SPLIT-exit edge, where it is executed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_addr  <= '0;
         l_width <= '0;
         l_sign  <= 1'b0;
         l_we    <= 1'b0;
         l_wdata <= '0;
      end else if (accept) begin
         l_addr  <= a_addr;
         l_width <= req_width;
         l_sign  <= req_sign;
         l_we    <= req_we;
         l_wdata <= req_wdata;
      end
   end
`else
   assign in_split = 1'b0;
`endif

   // Classify the incoming request: size, legality and whether it crosses a row.
   always_comb begin
      a_addr    = req_addr[ADDR_WIDTH-1:0];
      a_size    = 1 << req_width;
      a_illegal = (REG_WIDTH == 32) && (req_width == 2'd3);
      a_cross   = 1'b0;
`ifdef DATA_MEM_PIPE_MISALIGN_EN
      a_cross   = (int'(a_addr[OFFW-1:0]) + a_size) > NB;
`else
      if ((int'(a_addr[2:0]) & (a_size - 1)) != 0) a_illegal = 1'b1;
`endif
   end

   // Reset holds req_ready low until the first edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) up_q <= 1'b0;
      else     up_q <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: a legal row-crossing request spends one cycle in SPLIT.
   always_comb begin
      state_nxt = state;
`ifdef DATA_MEM_PIPE_MISALIGN_EN
      case (state)
         IDLE:    if (accept && a_cross && !a_illegal) state_nxt = SPLIT;
         SPLIT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
`endif
   end

   // Select the access performed on this edge: a fresh in-row request or the held split one.
   always_comb begin
      x_addr  = a_addr;
      x_width = req_width;
      x_sign  = req_sign;
      x_we    = req_we;
      x_wdata = req_wdata;
      x_go    = accept && !a_illegal && !a_cross;
`ifdef DATA_MEM_PIPE_MISALIGN_EN
      if (in_split) begin
         x_addr  = l_addr;
         x_width = l_width;
         x_sign  = l_sign;
         x_we    = l_we;
         x_wdata = l_wdata;
         x_go    = 1'b1;
      end
`endif
      x_size = 1 << x_width;
   end

   // Gather the addressed bytes (wrapping past the top) and extend to the full width.
   always_comb begin
      rd_raw = '0;
      for (int i = 0; i < NB; i++)
         if (i < x_size) rd_raw[8*i +: 8] = mem[x_addr + ADDR_WIDTH'(i)];
      case (x_width)
         2'd0:    rd_msb = rd_raw[7];
         2'd1:    rd_msb = rd_raw[15];
         2'd2:    rd_msb = rd_raw[31];
         default: rd_msb = rd_raw[REG_WIDTH-1];
      endcase
      rd_ext = rd_raw;
      for (int j = 0; j < REG_WIDTH; j++)
         if (j >= 8 * x_size) rd_ext[j] = rd_msb && !x_sign;
   end

   // Store the low bytes of the write data; a split store lands only on the SPLIT-exit edge.
   always_ff @(posedge clk) begin
      if (x_go && x_we)
         for (int i = 0; i < NB; i++)
            if (i < x_size) mem[x_addr + ADDR_WIDTH'(i)] <= x_wdata[8*i +: 8];
   end

   // Registered response: one pulse per accepted request, data only for legal loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= (accept && (a_illegal || !a_cross)) || in_split;
         resp_err   <= accept && a_illegal;
         resp_rdata <= (x_go && !x_we) ? rd_ext : '0;
      end
   end
endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe (REG_WIDTH=64, ADDR_WIDTH=10).
// A byte-array reference model predicts latency, error and load data per request.
// Covers reset, directed load/store cases, split/abort, mid-stream reset and random traffic.
module tb_data_mem_pipe;
`ifdef DATA_MEM_PIPE_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_sign;
   logic [1:0]  req_width;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata;

   always #5 clk = ~clk;

   data_mem_pipe #(.REG_WIDTH(64), .ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   logic [7:0] mdl [0:1023];
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [1:0] w, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd);
      req_valid = v; req_we = we; req_width = w; req_sign = sg; req_addr = a; req_wdata = wd;
   endtask

   // Reference: 1024-byte little-endian memory, wrap at the top, 8-byte rows.
   task automatic model(input logic we, input logic [1:0] w, input logic sg, input logic [63:0] addr,
                        input logic [63:0] wd, output logic err, output logic [63:0] rd, output int lat);
      int size, a;
      logic [63:0] v;
      size = 1 << w;
      a    = int'(addr[9:0]);
      err  = !MIS && ((a % size) != 0);
      lat  = (!err && ((a % 8) + size > 8)) ? 2 : 1;
      rd   = '0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < size; i++) mdl[(a + i) % 1024] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (64'(mdl[(a + i) % 1024]) << (8 * i));
            if (!sg && size < 8 && v[8*size-1]) v = v | ({64{1'b1}} << (8 * size));
            rd = v;
         end
      end
   endtask

   // One request in isolation; starts and ends at a negedge with the DUT idle.
   task automatic issue(input logic we, input logic [1:0] w, input logic sg, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] got, output int lat);
      logic e_err;
      logic [63:0] e_rd;
      int e_lat, n;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk_val("rdy_wait", req_ready, 1);
      model(we, w, sg, addr, wd, e_err, e_rd, e_lat);
      drive(1'b1, we, w, sg, addr, wd);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
      chk_val("split_rdy", req_ready, (e_lat == 2) ? 0 : 1);
      lat = 1;
      while (!resp_valid && lat < 6) begin @(negedge clk); lat++; end
      chk_val("lat", lat, e_lat);
      chk_val("err", resp_err, e_err);
      chk_val("rdata", resp_rdata, e_rd);
      chk_val("rdy_back", req_ready, 1);
      got = resp_rdata;
      @(negedge clk);
      chk_val("pulse", resp_valid, 0);
   endtask

   // Back-to-back aligned requests, one per cycle; fill=1 writes every row in order.
   task automatic burst(input int n, input bit fill);
      logic [63:0] exp_q[$];
      logic        err_q[$];
      logic [63:0] a, wd, e_rd;
      logic [1:0]  w;
      logic        we, sg, e_err;
      int          e_lat;
      for (int k = 0; k < n; k++) begin
         wd = {$urandom, $urandom};
         if (fill) begin
            we = 1'b1; w = 2'd3; sg = 1'b0; a = 64'(8 * k);
         end else begin
            we = 1'($urandom_range(0, 1));
            w  = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom} & ~(64'(1 << w) - 64'd1);
         end
         if (k > 0) begin
            chk_val("b2b_vld", resp_valid, 1);
            chk_val("b2b_err", resp_err, err_q.pop_front());
            chk_val("b2b_rdata", resp_rdata, exp_q.pop_front());
         end
         chk_val("b2b_rdy", req_ready, 1);
         model(we, w, sg, a, wd, e_err, e_rd, e_lat);
         exp_q.push_back(e_rd);
         err_q.push_back(e_err);
         drive(1'b1, we, w, sg, a, wd);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
      chk_val("b2b_vld_last", resp_valid, 1);
      chk_val("b2b_err_last", resp_err, err_q.pop_front());
      chk_val("b2b_rdata_last", resp_rdata, exp_q.pop_front());
      @(negedge clk);
      chk_val("b2b_pulse", resp_valid, 0);
   endtask

   // Row-crossing store cut short by reset: no response, memory untouched (model not updated).
   task automatic abort_split(input logic [1:0] w, input logic [63:0] addr, input logic [63:0] wd);
      chk_val("ab_rdy_pre", req_ready, 1);
      drive(1'b1, 1'b1, w, 1'b0, addr, wd);
      @(posedge clk);
      #2;
      rst = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
      #1;
      chk_val("ab_vld", resp_valid, 0);
      chk_val("ab_err", resp_err, 0);
      chk_val("ab_rdy", req_ready, 0);
      repeat (2) @(negedge clk);
      chk_val("ab_vld_hold", resp_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_val("ab_rdy_up", req_ready, 1);
   endtask

   initial begin
      logic [63:0] got;
      logic [7:0]  b_old;
      int          lat;
      logic [1:0]  w;

      rst = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
      repeat (3) @(negedge clk);
      chk_val("rst_vld", resp_valid, 0);
      chk_val("rst_err", resp_err, 0);
      chk_val("rst_rdata", resp_rdata, 0);
      chk_val("rst_rdy", req_ready, 0);
      rst = 1'b0;
      #1 chk_val("rel_rdy0", req_ready, 0);
      @(negedge clk);
      chk_val("rel_rdy1", req_ready, 1);

      burst(128, 1'b1);

      issue(1'b1, 2'd3, 1'b0, 64'h8, 64'h1122334455667788, got, lat);
      chk_val("d_st_lat", lat, 1);
      issue(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, got, lat);
      chk_val("d_ld_dbl", got, 64'h1122334455667788);
      chk_val("d_ld_lat", lat, 1);

      issue(1'b1, 2'd2, 1'b0, 64'h20, 64'h89ABCDEF, got, lat);
      issue(1'b0, 2'd2, 1'b0, 64'h20, 64'h0, got, lat);
      chk_val("d_ld_word_s", got, 64'hFFFFFFFF89ABCDEF);
      issue(1'b0, 2'd2, 1'b1, 64'h20, 64'h0, got, lat);
      chk_val("d_ld_word_u", got, 64'h0000000089ABCDEF);

      issue(1'b1, 2'd0, 1'b0, 64'h60, 64'hAA, got, lat);
      issue(1'b0, 2'd0, 1'b0, 64'h60, 64'h0, got, lat);
      chk_val("d_ld_byte_s", got, 64'hFFFFFFFFFFFFFFAA);
      issue(1'b0, 2'd0, 1'b1, 64'h60, 64'h0, got, lat);
      chk_val("d_ld_byte_u", got, 64'hAA);

      issue(1'b1, 2'd2, 1'b0, 64'h6, 64'hDEADBEEF, got, lat);
      chk_val("d_mis_st_lat", lat, MIS ? 2 : 1);
      issue(1'b0, 2'd2, 1'b0, 64'h6, 64'h0, got, lat);
      chk_val("d_mis_ld", got, MIS ? 64'hFFFFFFFFDEADBEEF : 64'h0);
      chk_val("d_mis_ld_lat", lat, MIS ? 2 : 1);
      for (int i = 6; i < 10; i++) issue(1'b0, 2'd0, 1'b1, 64'(i), 64'h0, got, lat);
      issue(1'b0, 2'd0, 1'b1, 64'h8, 64'h0, got, lat);
      chk_val("d_mis_b8", got, MIS ? 64'hAD : 64'h88);

      b_old = mdl[1023];
      issue(1'b1, 2'd1, 1'b0, 64'h3FF, 64'hBEEF, got, lat);
      issue(1'b0, 2'd0, 1'b1, 64'h3FF, 64'h0, got, lat);
      chk_val("d_wrap_b3ff", got, MIS ? 64'hEF : {56'h0, b_old});
      issue(1'b0, 2'd0, 1'b1, 64'h0, 64'h0, got, lat);

      abort_split(2'd2, 64'h3FE, 64'h55667788);
      for (int i = 0; i < 4; i++)
         issue(1'b0, 2'd0, 1'b1, 64'((1022 + i) % 1024), 64'h0, got, lat);

      issue(1'b1, 2'd3, 1'b0, 64'h100, 64'h0123456789ABCDEF, got, lat);
      drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0);
      @(posedge clk);
      #1 chk_val("mid_vld_pre", resp_valid, 1);
      #1 rst = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
      #1;
      chk_val("mid_vld", resp_valid, 0);
      chk_val("mid_err", resp_err, 0);
      chk_val("mid_rdata", resp_rdata, 0);
      chk_val("mid_rdy", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk_val("mid_rel_rdy0", req_ready, 0);
      @(negedge clk);
      chk_val("mid_rel_rdy1", req_ready, 1);
      issue(1'b0, 2'd3, 1'b0, 64'h100, 64'h0, got, lat);
      chk_val("mid_keep", got, 64'h0123456789ABCDEF);

      for (int k = 0; k < 200; k++) begin
         w = 2'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), {$urandom, $urandom},
               {$urandom, $urandom}, got, lat);
      end
      burst(60, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1);
   end
endmodule
